// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD arithmetic datapath (serial subtractor and
// combinational adder).
//   state_t  : control FSM states of the serial subtractor
//   BCD_MAX  : largest legal BCD digit value
//   BCD_BASE : decimal radix used for borrow/carry correction
//   is_bcd() : true when a nibble holds a legal decimal digit
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_MAX  = 9;
  localparam int BCD_BASE = 10;

  function automatic logic is_bcd(input logic [3:0] nib);
    return nib <= 4'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtractor, purely combinational.
//   a_d [3:0] : minuend digit
//   b_d [3:0] : subtrahend digit
//   bi        : borrow in
//   d   [3:0] : difference digit (0..9 for legal inputs)
//   bo        : borrow out
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  localparam logic signed [5:0] BASE_S = 6'(BCD_BASE);

  // Six bits keep the raw difference exact even for illegal (>9) nibbles.
  logic signed [5:0] t;
  logic signed [5:0] t_adj;

  assign t     = $signed({2'b00, a_d}) - $signed({2'b00, b_d}) - $signed({5'b00000, bi});
  assign t_adj = t + BASE_S;

  // A negative raw difference borrows ten from the next digit up.
  assign bo = t[5];
  assign d  = t[5] ? t_adj[3:0] : t[3:0];

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial multi-digit BCD subtractor, least-significant digit first.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   start : operation request, sampled only while idle
//   a, b  : packed BCD minuend / subtrahend, digit 0 in bits [3:0]
//   bin   : borrow into digit 0
//   diff  : packed BCD difference, held until the next accepted start
//   bout  : borrow out of the most-significant digit, held with diff
//   err   : an operand digit was >9 (diff and bout forced to 0), held with diff
//   busy  : high whenever the FSM is not idle
//   done  : one-cycle pulse marking a valid result
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DW     = 4 * DIGITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          bin,
  output logic [DW-1:0] diff,
  output logic          bout,
  output logic          err,
  output logic          busy,
  output logic          done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, b_q;
  logic [DW-1:0] diff_q;
  logic [IW-1:0] idx_q;
  logic          borrow_q;
  logic          err_pend_q;
  logic          bout_q;
  logic          err_q;
  logic          done_q;

  logic          bad_operand;
  logic [3:0]    dig_d;
  logic          dig_bo;

  // Operand legality is judged once, on the values being latched.
  always_comb begin
    bad_operand = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(a[4*i +: 4]) || !is_bcd(b[4*i +: 4])) begin
        bad_operand = 1'b1;
      end
    end
  end

  bcd_digit_sub u_digit (
    .a_d (a_q[3:0]),
    .b_d (b_q[3:0]),
    .bi  (borrow_q),
    .d   (dig_d),
    .bo  (dig_bo)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand shift registers: the current digit always sits in bits [3:0].
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      a_q <= a;
      b_q <= b;
    end else if (state_q == CALC) begin
      a_q <= a_q >> 4;
      b_q <= b_q >> 4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_q     <= '0;
      idx_q      <= '0;
      borrow_q   <= 1'b0;
      err_pend_q <= 1'b0;
      bout_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            borrow_q   <= bin;
            idx_q      <= '0;
            diff_q     <= '0;
            err_q      <= 1'b0;
            err_pend_q <= bad_operand;
          end
        end
        CALC: begin
          borrow_q <= dig_bo;
          idx_q    <= idx_q + 1'b1;
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) diff_q[4*i +: 4] <= dig_d;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          if (err_pend_q) begin
            diff_q <= '0;
            bout_q <= 1'b0;
            err_q  <= 1'b1;
          end else begin
            bout_q <= borrow_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_serial_sub.sv
module tb_bcd_serial_sub;

  localparam int DIGITS = 4;
  localparam int DW     = 4 * DIGITS;
  localparam int LAT    = DIGITS + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] a, b;
  logic          bin;
  logic [DW-1:0] diff;
  logic          bout, err, busy, done;

  int checks = 0;
  int errors = 0;

  bcd_serial_sub #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Decimal reference: convert to integers, subtract, wrap by 10^DIGITS.
  function automatic void model(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                input bit bi, output logic [DW-1:0] d,
                                output bit bo, output bit e);
    longint an = 0, bn = 0, p = 1, r;
    e = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (av[4*i +: 4] > 9 || bv[4*i +: 4] > 9) e = 1;
      an += longint'(av[4*i +: 4]) * p;
      bn += longint'(bv[4*i +: 4]) * p;
      p  *= 10;
    end
    r  = an - bn - longint'(bi);
    bo = 0;
    if (r < 0) begin
      r += p;
      bo = 1;
    end
    d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    if (e) begin
      d  = '0;
      bo = 0;
    end
  endfunction

  // Issues one operation and waits (bounded) for done; lat = -1 on timeout.
  task automatic run_op(input logic [DW-1:0] av, input logic [DW-1:0] bv, input bit bi,
                        output int lat, output logic [DW-1:0] d_o,
                        output bit bo_o, output bit e_o);
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = DW'($urandom); b = DW'($urandom); bin = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    d_o = diff; bo_o = bout; e_o = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (diff !== '0)  begin errors++; $display("FAIL reset_diff got %h want 0", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b want 0", bout); end
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [DW-1:0] ta [7] = '{16'h5432, 16'h0000, 16'h0000, 16'h1000, 16'h9999, 16'h12A4, 16'h0010};
    logic [DW-1:0] tb [7] = '{16'h1234, 16'h0001, 16'h0000, 16'h0001, 16'h9999, 16'h0001, 16'h0009};
    bit            tbi[7] = '{0, 0, 1, 0, 0, 0, 0};
    logic [DW-1:0] td [7] = '{16'h4198, 16'h9999, 16'h9999, 16'h0999, 16'h0000, 16'h0000, 16'h0001};
    bit            tbo[7] = '{0, 1, 1, 0, 0, 0, 0};
    bit            te [7] = '{0, 0, 0, 0, 0, 1, 0};
    int lat; logic [DW-1:0] d; bit bo, e;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], tbi[i], lat, d, bo, e);
      checks++; if (lat != LAT) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); end
      checks++; if (d !== td[i]) begin errors++; $display("FAIL dir%0d_diff got %h want %h", i, d, td[i]); end
      checks++; if (bo !== tbo[i]) begin errors++; $display("FAIL dir%0d_bout got %b want %b", i, bo, tbo[i]); end
      checks++; if (e !== te[i]) begin errors++; $display("FAIL dir%0d_err got %b want %b", i, e, te[i]); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b want 0", i, done); end
    end
  endtask

  task automatic test_err_clear();
    int lat; logic [DW-1:0] d; bit bo, e;
    run_op(16'h00F0, 16'h0000, 1'b0, lat, d, bo, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL errclr_set got %b want 1", e); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL errclr_held got %b want 1", err); end
    @(negedge clk); a = 16'h0005; b = 16'h0003; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL errclr_on_accept got %b want 0", err); end
    repeat (LAT) @(posedge clk);
    #1;
    checks++; if (diff !== 16'h0002) begin errors++; $display("FAIL errclr_diff got %h want 0002", diff); end
  endtask

  task automatic test_random();
    int lat; logic [DW-1:0] av, bv, d, dm; bit bi, bo, e, bom, em;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        av[4*i +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        bv[4*i +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      end
      bi = 1'($urandom);
      model(av, bv, bi, dm, bom, em);
      run_op(av, bv, bi, lat, d, bo, e);
      checks++; if (lat != LAT) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", n, lat, LAT); end
      checks++; if (d !== dm) begin errors++; $display("FAIL rnd%0d_diff a=%h b=%h bin=%b got %h want %h", n, av, bv, bi, d, dm); end
      checks++; if (bo !== bom) begin errors++; $display("FAIL rnd%0d_bout got %b want %b", n, bo, bom); end
      checks++; if (e !== em) begin errors++; $display("FAIL rnd%0d_err got %b want %b", n, e, em); end
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0; int first = -1; int second = -1;
    @(negedge clk); a = 16'h0050; b = 16'h0017; bin = 1'b0; start = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (c == 9) start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) first = c; else if (second < 0) second = c;
        checks++; if (diff !== 16'h0033) begin errors++; $display("FAIL b2b_diff got %h want 0033", diff); end
      end
    end
    checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", ndone); end
    checks++; if (first != LAT) begin errors++; $display("FAIL b2b_first got %0d want %0d", first, LAT); end
    checks++; if (second != LAT + DIGITS + 2) begin errors++; $display("FAIL b2b_second got %0d want %0d", second, LAT + DIGITS + 2); end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    @(negedge clk); a = 16'h5432; b = 16'h1234; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); a = 16'h0000; b = 16'h0001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        checks++; if (diff !== 16'h4198) begin errors++; $display("FAIL ignore_diff got %h want 4198", diff); end
      end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_count got %0d want 1", ndone); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got %b want 0", busy); end
  endtask

  task automatic test_busy();
    @(negedge clk); a = 16'h0002; b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k <= DIGITS; k++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_c%0d got %b want 1", k, busy); end
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end got %b want 0", busy); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_done got %b want 1", done); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0; int lat; logic [DW-1:0] d; bit bo, e;
    @(negedge clk); a = 16'h9876; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (diff !== '0)  begin errors++; $display("FAIL rstmid_diff got %h want 0", diff); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
    checks++; if ({bout, err} !== 2'b00) begin errors++; $display("FAIL rstmid_flags got %b want 00", {bout, err}); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_nodone got %0d want 0", ndone); end
    run_op(16'h0010, 16'h0009, 1'b0, lat, d, bo, e);
    checks++; if (lat != LAT) begin errors++; $display("FAIL rstmid_latency got %0d want %0d", lat, LAT); end
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL rstmid_after_diff got %h want 0001", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL rstmid_after_bout got %b want 0", bo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_err_clear();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_busy();
    test_reset_mid();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
